fp16_addsub_sequencer: RTL and testbench



---
 rtl/fp16_addsub_sequencer_if.sv | 34 +++
 rtl/fp16_addsub_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_fp16_addsub_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/fp16_addsub_sequencer_if.sv
// Operand/result bundle for the binary16 add/subtract sequencer.
// Handshake: the master holds a, b and op stable and raises start while the
// slave is idle (busy=0); the slave takes the operands on that rising edge,
// holds busy high until its single-cycle done pulse, and keeps result stable
// from the done cycle until the next done cycle.
interface fp16_addsub_sequencer_if;
    logic        start;
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;

    modport master (
        output start,
        output op,
        output a,
        output b,
        input  busy,
        input  done,
        input  result
    );

    modport slave (
        input  start,
        input  op,
        input  a,
        input  b,
        output busy,
        output done,
        output result
    );
endinterface

// File: rtl/fp16_addsub_sequencer.sv
// Multi-cycle binary16 add/subtract: unpack, magnitude swap, bit-serial
// alignment, mantissa add/sub, bit-serial normalization, truncating pack.
// Subnormal inputs and underflowing results are flushed to signed zero.
module fp16_addsub_sequencer (
    input  logic                        clk,
    input  logic                        rst_n,
    fp16_addsub_sequencer_if.slave      bus,
    output logic [2:0]                  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UNPACK = 3'd1,
        S_SWAP   = 3'd2,
        S_ALIGN  = 3'd3,
        S_ADD    = 3'd4,
        S_NORM   = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t      state, state_nxt;

    // Captured operands
    logic [15:0] a_r, a_nxt;
    logic [15:0] b_r, b_nxt;
    logic        op_r, op_nxt;

    // Working datapath: L is the larger-magnitude operand, S the smaller
    logic        sign_l, sign_l_nxt;
    logic        sign_s, sign_s_nxt;
    logic [4:0]  exp_r, exp_nxt;
    logic [11:0] m_l, m_l_nxt;
    logic [11:0] m_s, m_s_nxt;
    logic [11:0] m_r, m_r_nxt;
    logic [4:0]  d_r, d_nxt;
    logic [15:0] result_r, result_nxt;

    // Field decode of the captured operands
    logic [4:0]  ea, eb;
    logic [9:0]  fa, fb;
    logic        sa, sb;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic        a_ge_b;
    logic [4:0]  swap_d;

    assign ea     = a_r[14:10];
    assign eb     = b_r[14:10];
    assign fa     = a_r[9:0];
    assign fb     = b_r[9:0];
    assign sa     = a_r[15];
    assign sb     = b_r[15] ^ op_r;
    assign a_nan  = (ea == 5'd31) && (fa != 10'd0);
    assign b_nan  = (eb == 5'd31) && (fb != 10'd0);
    assign a_inf  = (ea == 5'd31) && (fa == 10'd0);
    assign b_inf  = (eb == 5'd31) && (fb == 10'd0);
    assign a_zero = (ea == 5'd0);
    assign b_zero = (eb == 5'd0);
    assign a_ge_b = (a_r[14:0] >= b_r[14:0]);
    assign swap_d = a_ge_b ? (ea - eb) : (eb - ea);

    // Mantissa add/sub and the two normalization step candidates
    logic [11:0] add_sum;
    logic [11:0] m_down, m_up;
    logic [4:0]  exp_inc, exp_dec;

    assign add_sum = (sign_l == sign_s) ? (m_l + m_s) : (m_l - m_s);
    assign m_down  = {1'b0, m_r[11:1]};
    assign m_up    = {m_r[10:0], 1'b0};
    assign exp_inc = exp_r + 5'd1;
    assign exp_dec = exp_r - 5'd1;

    assign bus.busy   = (state != S_IDLE);
    assign bus.done   = (state == S_DONE);
    assign bus.result = result_r;
    assign dbg_state  = state;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and next datapath values for every phase of the operation
    always_comb begin
        state_nxt  = state;
        a_nxt      = a_r;
        b_nxt      = b_r;
        op_nxt     = op_r;
        sign_l_nxt = sign_l;
        sign_s_nxt = sign_s;
        exp_nxt    = exp_r;
        m_l_nxt    = m_l;
        m_s_nxt    = m_s;
        m_r_nxt    = m_r;
        d_nxt      = d_r;
        result_nxt = result_r;

        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    a_nxt     = bus.a;
                    b_nxt     = bus.b;
                    op_nxt    = bus.op;
                    state_nxt = S_UNPACK;
                end
            end

            S_UNPACK: begin
                state_nxt = S_DONE;
                if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
                    result_nxt = 16'h7E00;
                end else if (a_inf) begin
                    result_nxt = {sa, 5'd31, 10'd0};
                end else if (b_inf) begin
                    result_nxt = {sb, 5'd31, 10'd0};
                end else if (a_zero && b_zero) begin
                    result_nxt = {sa & sb, 15'd0};
                end else if (a_zero) begin
                    result_nxt = {sb, b_r[14:0]};
                end else if (b_zero) begin
                    result_nxt = {sa, a_r[14:0]};
                end else begin
                    state_nxt = S_SWAP;
                end
            end

            S_SWAP: begin
                if (a_ge_b) begin
                    sign_l_nxt = sa;
                    sign_s_nxt = sb;
                    exp_nxt    = ea;
                    m_l_nxt    = {2'b01, fa};
                    m_s_nxt    = {2'b01, fb};
                end else begin
                    sign_l_nxt = sb;
                    sign_s_nxt = sa;
                    exp_nxt    = eb;
                    m_l_nxt    = {2'b01, fb};
                    m_s_nxt    = {2'b01, fa};
                end
                d_nxt     = swap_d;
                state_nxt = (swap_d == 5'd0) ? S_ADD : S_ALIGN;
            end

            S_ALIGN: begin
                if (d_r >= 5'd12) begin
                    // Everything would shift out; clear in one step
                    m_s_nxt   = 12'd0;
                    d_nxt     = 5'd0;
                    state_nxt = S_ADD;
                end else begin
                    m_s_nxt = {1'b0, m_s[11:1]};
                    d_nxt   = d_r - 5'd1;
                    if (d_r == 5'd1) begin
                        state_nxt = S_ADD;
                    end
                end
            end

            S_ADD: begin
                m_r_nxt = add_sum;
                if (add_sum == 12'd0) begin
                    result_nxt = 16'h0000;
                    state_nxt  = S_DONE;
                end else if (add_sum[11] || !add_sum[10]) begin
                    state_nxt = S_NORM;
                end else begin
                    result_nxt = {sign_l, exp_r, add_sum[9:0]};
                    state_nxt  = S_DONE;
                end
            end

            S_NORM: begin
                if (m_r[11]) begin
                    // Carry out: one right shift always lands on bit 10
                    m_r_nxt   = m_down;
                    exp_nxt   = exp_inc;
                    state_nxt = S_DONE;
                    if (exp_inc == 5'd31) begin
                        result_nxt = {sign_l, 5'd31, 10'd0};
                    end else begin
                        result_nxt = {sign_l, exp_inc, m_down[9:0]};
                    end
                end else begin
                    m_r_nxt = m_up;
                    exp_nxt = exp_dec;
                    if (exp_dec == 5'd0) begin
                        result_nxt = {sign_l, 15'd0};
                        state_nxt  = S_DONE;
                    end else if (m_up[10]) begin
                        result_nxt = {sign_l, exp_dec, m_up[9:0]};
                        state_nxt  = S_DONE;
                    end
                end
            end

            S_DONE: begin
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r      <= 16'd0;
            b_r      <= 16'd0;
            op_r     <= 1'b0;
            sign_l   <= 1'b0;
            sign_s   <= 1'b0;
            exp_r    <= 5'd0;
            m_l      <= 12'd0;
            m_s      <= 12'd0;
            m_r      <= 12'd0;
            d_r      <= 5'd0;
            result_r <= 16'h0000;
        end else begin
            a_r      <= a_nxt;
            b_r      <= b_nxt;
            op_r     <= op_nxt;
            sign_l   <= sign_l_nxt;
            sign_s   <= sign_s_nxt;
            exp_r    <= exp_nxt;
            m_l      <= m_l_nxt;
            m_s      <= m_s_nxt;
            m_r      <= m_r_nxt;
            d_r      <= d_nxt;
            result_r <= result_nxt;
        end
    end

endmodule

// File: tb/tb_fp16_addsub_sequencer.sv
// Directed bench for fp16_addsub_sequencer: expected results and DONE
// latencies go into queues when an operation is launched and are popped
// when the done pulse arrives.
module tb_fp16_addsub_sequencer;

    logic       clk;
    logic       rst_n;
    logic [2:0] dbg_state;

    fp16_addsub_sequencer_if bus();

    fp16_addsub_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];
    int          lat_q[$];

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Launch one operation, wait (bounded) for done, then score it
    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic top, input logic [15:0] exp_res, input int exp_cyc);
        int          cyc;
        logic [15:0] want;
        int          want_cyc;
        exp_q.push_back(exp_res);
        lat_q.push_back(exp_cyc);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb_v;
        bus.op    = top;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        check({tag, "_busy1"}, {15'd0, bus.busy}, 16'd1);
        while (!bus.done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        want     = exp_q.pop_front();
        want_cyc = lat_q.pop_front();
        if (!bus.done) begin
            checks++;
            errors++;
            $error("FAIL %s_timeout: observed no done expected done by cycle %0d", tag, want_cyc);
        end else begin
            check({tag, "_res"}, bus.result, want);
            check({tag, "_cyc"}, 16'(cyc), 16'(want_cyc));
            check({tag, "_busy_done"}, {15'd0, bus.busy}, 16'd1);
        end
        @(negedge clk);
        check({tag, "_idle_busy"}, {15'd0, bus.busy}, 16'd0);
        check({tag, "_idle_done"}, {15'd0, bus.done}, 16'd0);
        check({tag, "_hold"}, bus.result, want);
    endtask

    initial begin
        int cyc;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a     = 16'h0000;
        bus.b     = 16'h0000;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {15'd0, bus.busy}, 16'd0);
        check("rst_done", {15'd0, bus.done}, 16'd0);
        check("rst_result", bus.result, 16'h0000);
        rst_n = 1'b1;

        // Normal arithmetic paths
        run_op("one_plus_one",   16'h3C00, 16'h3C00, 1'b0, 16'h4000, 5);
        run_op("one_plus_half",  16'h3C00, 16'h3800, 1'b0, 16'h3E00, 5);
        run_op("one_minus_one",  16'h3C00, 16'h3C00, 1'b1, 16'h0000, 4);
        run_op("one_plus_mhalf", 16'h3C00, 16'hB800, 1'b0, 16'h3800, 6);
        run_op("half_minus_one", 16'h3800, 16'h3C00, 1'b1, 16'hB800, 6);
        run_op("overflow",       16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 5);
        run_op("align_d12",      16'h3C00, 16'h0C00, 1'b0, 16'h3C00, 5);
        run_op("cancel",         16'h3C01, 16'h3C00, 1'b1, 16'h1400, 14);
        run_op("underflow",      16'h0401, 16'h0400, 1'b1, 16'h0000, 5);

        // Special operands resolved in UNPACK
        run_op("inf_minus_inf",  16'h7C00, 16'hFC00, 1'b0, 16'h7E00, 2);
        run_op("inf_sub_ninf",   16'h7C00, 16'hFC00, 1'b1, 16'h7C00, 2);
        run_op("ninf_plus_one",  16'hFC00, 16'h3C00, 1'b0, 16'hFC00, 2);
        run_op("nan_in",         16'h7E01, 16'h3C00, 1'b0, 16'h7E00, 2);
        run_op("zero_minus_one", 16'h0000, 16'h3C00, 1'b1, 16'hBC00, 2);
        run_op("nz_plus_nz",     16'h8000, 16'h8000, 1'b0, 16'h8000, 2);
        run_op("nz_minus_z",     16'h8000, 16'h0000, 1'b1, 16'h8000, 2);
        run_op("subnorm_flush",  16'h0001, 16'h0001, 1'b0, 16'h0000, 2);

        // start pulses while busy and in DONE are ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h3C00;
        bus.b     = 16'h3C00;
        bus.op    = 1'b0;
        @(negedge clk);
        bus.a     = 16'h4400;
        bus.b     = 16'h4400;
        bus.op    = 1'b1;
        cyc = 1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 2;
        while (!bus.done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("ignore_res", bus.result, 16'h4000);
        check("ignore_cyc", 16'(cyc), 16'd5);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) begin
            check("ignore_idle_busy", {15'd0, bus.busy}, 16'd0);
            @(negedge clk);
        end
        check("ignore_hold", bus.result, 16'h4000);

        // Reset during ALIGN aborts with no done
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'h3C00;
        bus.b     = 16'h2800;
        bus.op    = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("align_state", {13'd0, dbg_state}, 16'd3);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", {15'd0, bus.busy}, 16'd0);
        check("abort_done", {15'd0, bus.done}, 16'd0);
        check("abort_result", bus.result, 16'h0000);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check("abort_no_done", {15'd0, bus.done}, 16'd0);
        end

        // Fresh operation after the abort
        run_op("after_reset", 16'h3C00, 16'h2800, 1'b0, 16'h3C20, 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
